// File: rtl/uart_tx_param.sv
// uart_tx_param: single-clock UART transmitter with an integrated synchronous FIFO
// and an internal baud divider. Frames are start + DATA_BITS (LSB first)
// + optional even parity + STOP_BITS stop bits; each bit lasts BAUD_DIV clocks.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 17,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 TX_en,
  input  logic [DATA_BITS-1:0] TX_Data_in,
  output logic                 TX_Ready,
  output logic [LVL_W-1:0]     TX_Level,
  output logic                 TX_Busy,
  output logic                 TX_Overflow,
  output logic                 TX_Data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0]    DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]    STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ready_q, ovf_q;
  logic                 fifo_empty, fifo_full, push, pop;
  logic [DATA_BITS-1:0] rd_data;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 baud_tc, line_c, txd_q, busy_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Reset asserts immediately but is released synchronously to clk.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // An extra wrap bit on each pointer distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = TX_en & ~fifo_full;
  assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign baud_tc    = (baud_q == BAUD_LAST);

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= TX_Data_in;
  end

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers, registered level/ready and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != FULL_LVL);
      ovf_q   <= TX_en & fifo_full;
    end
  end

  // Frame sequencer: next state, baud count, bit index, shift register and line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    line_c  = 1'b1;
    if (state_q != S_IDLE) baud_d = baud_tc ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = rd_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^rd_data;
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        line_c = 1'b0;
        if (baud_tc) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line_c = shift_q[0];
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line_c = par_q;
        if (baud_tc) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        line_c = 1'b1;
        if (baud_tc) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Back-to-back: the next word skips IDLE and starts immediately.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = rd_data;
`ifdef UART_TX_PARITY_EN
              par_d   = ^rd_data;
`endif
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and the glitch-free registered line / busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= line_c;
      busy_q  <= (state_q != S_IDLE);
    end
  end

  // Shift register (and stored parity) are pure data, loaded at pop time.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign TX_Ready    = ready_q;
  assign TX_Level    = level_q;
  assign TX_Busy     = busy_q;
  assign TX_Overflow = ovf_q;
  assign TX_Data_out = txd_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param: one 8N1 instance (BAUD_DIV=4, FIFO_DEPTH=4)
// and one 5-data-bit, 2-stop-bit instance sharing clock and reset.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int FL  = 44;
  localparam int FLB = 36;
`else
  localparam int FL  = 40;
  localparam int FLB = 32;
`endif

  logic       clk = 1'b0;
  logic       reset_b;
  logic       a_en, a_ready, a_busy, a_ovf, a_txd;
  logic [7:0] a_din;
  logic [2:0] a_level;
  logic       b_en, b_ready, b_busy, b_ovf, b_txd;
  logic [4:0] b_din;
  logic [2:0] b_level;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_b(reset_b), .TX_en(a_en), .TX_Data_in(a_din),
    .TX_Ready(a_ready), .TX_Level(a_level), .TX_Busy(a_busy),
    .TX_Overflow(a_ovf), .TX_Data_out(a_txd)
  );

  uart_tx_param #(.DATA_BITS(5), .STOP_BITS(2), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_b(reset_b), .TX_en(b_en), .TX_Data_in(b_din),
    .TX_Ready(b_ready), .TX_Level(b_level), .TX_Busy(b_busy),
    .TX_Overflow(b_ovf), .TX_Data_out(b_txd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the start bit begins, for an 8-bit word.
  function automatic logic fbit(input logic [7:0] d, input int k);
    int idx;
    idx = k / 4;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Push one word into idle dut_a and check the whole frame against hand-written bits.
  task automatic frame_a(input string tag, input logic [7:0] data,
                         input logic [15:0] bits, input int nbits);
    a_en = 1'b1; a_din = data;
    step();
    a_en = 1'b0;
    chk({tag, "_lvl"}, 32'(a_level), 32'd1);
    step();
    chk({tag, "_pre"}, 32'(a_txd), 32'd1);
    for (int k = 0; k < nbits * 4; k++) begin
      step();
      chk({tag, "_line"}, 32'(a_txd), 32'(bits[k/4]));
      chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    end
    step();
    chk({tag, "_post_line"}, 32'(a_txd), 32'd1);
    chk({tag, "_post_busy"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] w[6];
    int lv[6];
    int rdy[6];
    int ov[6];
    int cyc;
    int lows;

    reset_b = 1'b0;
    a_en = 1'b0; a_din = '0;
    b_en = 1'b0; b_din = '0;
    repeat (3) step();

    // Reset state
    chk("rst_txd",   32'(a_txd),   32'd1);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_ovf",   32'(a_ovf),   32'd0);
    chk("rst_b_txd", 32'(b_txd),   32'd1);
    reset_b = 1'b1;
    repeat (4) step();

    // Single frames: 0xA5 and 0x07
`ifdef UART_TX_PARITY_EN
    frame_a("t2_a5", 8'hA5, 16'h054A, 11);
    frame_a("t2_07", 8'h07, 16'h060E, 11);
`else
    frame_a("t1_a5", 8'hA5, 16'h034A, 10);
    frame_a("t1_07", 8'h07, 16'h020E, 10);
`endif
    repeat (2) step();

    // Six consecutive pushes into a depth-4 FIFO
    w   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    lv  = '{1, 1, 2, 3, 4, 4};
    rdy = '{1, 1, 1, 1, 0, 0};
    ov  = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      a_en = 1'b1; a_din = w[i];
      step();
      chk("t3_level", 32'(a_level), 32'(lv[i]));
      chk("t3_ready", 32'(a_ready), 32'(rdy[i]));
      chk("t3_ovf",   32'(a_ovf),   32'(ov[i]));
      chk("t3_line",  32'(a_txd),   (i < 2) ? 32'd1 : 32'd0);
    end
    a_en = 1'b0;
    for (int s = 4; s < 5 * FL; s++) begin
      step();
      if (s == 4) chk("t3_ovf_end", 32'(a_ovf), 32'd0);
      chk("t3_b2b_line", 32'(a_txd), 32'(fbit(w[s/FL], s % FL)));
      chk("t3_b2b_busy", 32'(a_busy), 32'd1);
    end
    step();
    chk("t3_idle_line",  32'(a_txd),   32'd1);
    chk("t3_idle_busy",  32'(a_busy),  32'd0);
    chk("t3_idle_level", 32'(a_level), 32'd0);
    chk("t3_idle_ready", 32'(a_ready), 32'd1);
    repeat (2) step();

    // Push on the edge where STOP ends: full -> dropped; one below full -> accepted
    for (int i = 0; i < 5; i++) begin
      a_en = 1'b1; a_din = w[i];
      step();
    end
    a_en = 1'b0;
    chk("t4_full_level", 32'(a_level), 32'd4);
    chk("t4_full_ready", 32'(a_ready), 32'd0);
    repeat (36) step();
    a_en = 1'b1; a_din = 8'h99;
    step();
    a_en = 1'b0;
    chk("t4_drop_ovf",   32'(a_ovf),   32'd1);
    chk("t4_drop_level", 32'(a_level), 32'd3);
    chk("t4_drop_ready", 32'(a_ready), 32'd1);
    chk("t4_drop_line",  32'(a_txd),   32'd1);
    step();
    chk("t4_next_start", 32'(a_txd), 32'd0);
    chk("t4_ovf_clear",  32'(a_ovf), 32'd0);
    repeat (38) step();
    a_en = 1'b1; a_din = 8'h5A;
    step();
    a_en = 1'b0;
    chk("t4_acc_ovf",   32'(a_ovf),   32'd0);
    chk("t4_acc_level", 32'(a_level), 32'd3);
    cyc = 0;
    while ((a_busy || a_level != 0) && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("t4_drain_cycles", 32'(cyc), 32'd161);
    chk("t4_drain_line",   32'(a_txd), 32'd1);
    repeat (2) step();

    // Reset mid-DATA with two words queued
    w[0] = 8'h00; w[1] = 8'h33; w[2] = 8'h44;
    for (int i = 0; i < 3; i++) begin
      a_en = 1'b1; a_din = w[i];
      step();
    end
    a_en = 1'b0;
    chk("t5_queued", 32'(a_level), 32'd2);
    repeat (8) step();
    chk("t5_mid_data_line", 32'(a_txd), 32'd0);
    #1;
    reset_b = 1'b0;
    #1;
    chk("t5_rst_line",  32'(a_txd),   32'd1);
    chk("t5_rst_level", 32'(a_level), 32'd0);
    chk("t5_rst_busy",  32'(a_busy),  32'd0);
    chk("t5_rst_ready", 32'(a_ready), 32'd1);
    repeat (2) step();
    reset_b = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (a_txd !== 1'b1 || a_busy !== 1'b0) lows++;
    end
    chk("t5_no_frames", 32'(lows), 32'd0);
    chk("t5_level_after", 32'(a_level), 32'd0);

    // 5 data bits, 2 stop bits: 0x1F
    b_en = 1'b1; b_din = 5'h1F;
    step();
    b_en = 1'b0;
    chk("t6_level", 32'(b_level), 32'd1);
    step();
    chk("t6_pre", 32'(b_txd), 32'd1);
    for (int k = 0; k < FLB; k++) begin
      step();
      chk("t6_line", 32'(b_txd), (k < 4) ? 32'd0 : 32'd1);
      chk("t6_busy", 32'(b_busy), 32'd1);
    end
    step();
    chk("t6_post_line", 32'(b_txd),  32'd1);
    chk("t6_post_busy", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
